aes128_iter_core: RTL and testbench

Iterative AES-128 engine covering both encryption and decryption, selected per block by a mode input. It takes a 128-bit cipher key once, expands and caches all 11 round keys, then processes blocks through a valid/ready handshake. Successor to the fixed decrypt-only datapath: it adds mode selection, a configurable unroll factor, key caching and flow control. It sits between the host data path and any framing or CBC/CTR logic.

---
 rtl/aes_pkg.sv | 79 +++++++
 rtl/aes_round.sv | 38 +++
 rtl/aes128_iter_core.sv | 129 ++++++++++++
 tb/tb_aes128_iter_core.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types and GF(2^8) helpers for the iterative core.
// The S-boxes are computed as GF inverse plus affine map, so no 256-entry table is needed.
package aes_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_KEXP, ST_RUN, ST_HOLD} state_t;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(x3, x3);
    x12  = gf_mul(x12, x12);
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // rk[i] -> rk[i+1]; the Rcon for round key i+1 sits at RCON[i]
  function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [3:0] i);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {RCON[i], 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round, forward or inverse; bit 127 is the MSB of byte 0,
// bytes are column-major (byte n = row n%4, column n/4).
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         mode,
  input  logic         last,
  output logic [127:0] nxt
);

  logic [127:0] enc_sr, dec_sr, enc_mc, dec_ark, dec_mc;

  // Byte substitution commutes with the row shift, so both happen in one gather
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW   = gi % 4;
    localparam int COL   = gi / 4;
    localparam int SRC_E = ROW + 4 * ((COL + ROW) % 4);
    localparam int SRC_D = ROW + 4 * ((COL + 4 - ROW) % 4);
    assign enc_sr[127-8*gi -: 8] = sbox(st[127-8*SRC_E -: 8]);
    assign dec_sr[127-8*gi -: 8] = inv_sbox(st[127-8*SRC_D -: 8]);
  end

  assign dec_ark = dec_sr ^ rk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign enc_mc[127-32*gi -: 32] = mix_col(enc_sr[127-32*gi -: 32]);
    assign dec_mc[127-32*gi -: 32] = inv_mix_col(dec_ark[127-32*gi -: 32]);
  end

  always_comb begin
    nxt = '0;
    if (mode) nxt = last ? dec_ark : dec_mc;
    else      nxt = (last ? enc_sr : enc_mc) ^ rk;
  end

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encrypt/decrypt engine with cached round keys,
// UNROLL rounds per clock and valid/ready flow control on both sides.
module aes128_iter_core
  import aes_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [0:127] cipher_key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [0:127] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] data_out
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
    $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
  end

  state_t       state_reg, state_next;
  logic         key_ok_reg, out_valid_reg, mode_reg;
  logic [3:0]   rnd_reg, kidx_reg;
  logic [127:0] blk_reg, data_out_reg;
  logic [127:0] rk_w [11];
  logic [127:0] kstep_w, round_out, din_w, key_w;
  logic         accept, load_key, kexp_done, run_done;

  assign din_w     = data_in;
  assign key_w     = cipher_key;
  assign in_ready  = (state_reg == ST_IDLE) && key_ok_reg && !key_load;
  assign accept    = in_valid && in_ready;
  assign load_key  = (state_reg == ST_IDLE) && key_load;
  assign kexp_done = (state_reg == ST_KEXP) && (kidx_reg == 4'd9);
  assign run_done  = (state_reg == ST_RUN) && (rnd_reg + 4'(UNROLL) == 4'd10);
  assign kstep_w   = key_step(rk_w[kidx_reg], kidx_reg);
  assign out_valid = out_valid_reg;
  assign data_out  = data_out_reg;

  // Each cached round key is its own register so KEXP writes exactly one per cycle
  for (genvar gi = 0; gi < 11; gi++) begin : g_rk
    logic [127:0] rk_reg;
    always_ff @(posedge clk) begin
      if (rst) rk_reg <= '0;
      else if (gi == 0) begin
        if (load_key) rk_reg <= key_w;
      end else if (state_reg == ST_KEXP && kidx_reg == 4'(gi - 1)) rk_reg <= kstep_w;
    end
    assign rk_w[gi] = rk_reg;
  end

  // Round r uses rk[r] forward and rk[10-r] inverse
  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_stage
    logic [3:0]   r_num;
    logic [127:0] st_in, st_out, rk_sel;
    assign r_num  = rnd_reg + 4'(gi + 1);
    assign rk_sel = mode_reg ? rk_w[4'd10 - r_num] : rk_w[r_num];
    if (gi == 0) begin : g_first
      assign st_in = blk_reg;
    end else begin : g_chain
      assign st_in = g_stage[gi-1].st_out;
    end
    aes_round u_round (
      .st   (st_in),
      .rk   (rk_sel),
      .mode (mode_reg),
      .last (r_num == 4'd10),
      .nxt  (st_out)
    );
  end
  assign round_out = g_stage[UNROLL-1].st_out;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (key_load) state_next = ST_KEXP;
               else if (accept) state_next = ST_RUN;
      ST_KEXP: if (kexp_done) state_next = ST_IDLE;
      ST_RUN:  if (run_done) state_next = ST_HOLD;
      ST_HOLD: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_ok_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      mode_reg      <= 1'b0;
      rnd_reg       <= '0;
      kidx_reg      <= '0;
      blk_reg       <= '0;
      data_out_reg  <= '0;
    end else begin
      if (load_key) begin
        key_ok_reg <= 1'b0;
        kidx_reg   <= '0;
      end
      if (state_reg == ST_KEXP) begin
        kidx_reg <= kexp_done ? 4'd0 : kidx_reg + 4'd1;
        if (kexp_done) key_ok_reg <= 1'b1;
      end
      if (accept) begin
        mode_reg <= mode;
        blk_reg  <= din_w ^ (mode ? rk_w[10] : rk_w[0]);
        rnd_reg  <= '0;
      end
      if (state_reg == ST_RUN) begin
        blk_reg <= round_out;
        rnd_reg <= run_done ? 4'd0 : rnd_reg + 4'(UNROLL);
        if (run_done) begin
          data_out_reg  <= round_out;
          out_valid_reg <= 1'b1;
        end
      end
      if (state_reg == ST_HOLD && out_ready) out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed bench for aes128_iter_core using FIPS-197 vectors on UNROLL = 1, 2 and 10 instances.
module tb_aes128_iter_core;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst [3];
  logic         key_load [3];
  logic         in_valid [3];
  logic         mode [3];
  logic         out_ready [3];
  logic [0:127] cipher_key [3];
  logic [0:127] data_in [3];
  logic         in_ready [3];
  logic         out_valid [3];
  logic [0:127] data_out [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    aes128_iter_core #(.UNROLL(gi == 0 ? 1 : (gi == 1 ? 2 : 10))) u_dut (
      .clk        (clk),
      .rst        (rst[gi]),
      .key_load   (key_load[gi]),
      .cipher_key (cipher_key[gi]),
      .in_valid   (in_valid[gi]),
      .in_ready   (in_ready[gi]),
      .mode       (mode[gi]),
      .data_in    (data_in[gi]),
      .out_valid  (out_valid[gi]),
      .out_ready  (out_ready[gi]),
      .data_out   (data_out[gi])
    );
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic load_key(input int u, input logic [127:0] key);
    int n;
    key_load[u]   = 1'b1;
    cipher_key[u] = key;
    tick();
    key_load[u] = 1'b0;
    n = 0;
    while (!in_ready[u] && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("key_ok_latency_u%0d", u), 128'(n), 128'd10);
    $display("key   u=%0d key=%h ready_after=%0d", u, key, n);
  endtask

  // Accept one block and wait for OUT_VALID; optionally pulse KEY_LOAD mid-run
  task automatic start_block(input int u, input logic m, input logic [127:0] din,
                             input logic [127:0] expv, input int lat, input int rekey_at);
    int n;
    check($sformatf("in_ready_before_accept_u%0d", u), 128'(in_ready[u]), 128'd1);
    in_valid[u] = 1'b1;
    mode[u]     = m;
    data_in[u]  = din;
    tick();
    in_valid[u] = 1'b0;
    data_in[u]  = '0;
    n = 0;
    while (!out_valid[u] && n < 40) begin
      if (n == rekey_at) begin
        key_load[u]   = 1'b1;
        cipher_key[u] = KEY_C;
      end
      tick();
      key_load[u] = 1'b0;
      n++;
    end
    check($sformatf("latency_u%0d_m%0d", u, m), 128'(n), 128'(lat));
    check($sformatf("data_out_u%0d_m%0d", u, m), data_out[u], expv);
    $display("block u=%0d mode=%0d in=%h out=%h latency=%0d", u, m, din, data_out[u], n);
  endtask

  task automatic finish_block(input int u);
    tick();
    check($sformatf("out_valid_drop_u%0d", u), 128'(out_valid[u]), 128'd0);
    check($sformatf("in_ready_back_u%0d", u), 128'(in_ready[u]), 128'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;  key_load[i] = 1'b0; in_valid[i] = 1'b0; mode[i] = 1'b0;
      out_ready[i] = 1'b1; cipher_key[i] = '0; data_in[i] = '0;
    end

    // Reset, with IN_VALID pulses that must be ignored
    for (int c = 0; c < 3; c++) begin
      in_valid[0] = c[0];
      data_in[0]  = PT_B;
      tick();
      check("rst_in_ready", 128'(in_ready[0]), 128'd0);
      check("rst_out_valid", 128'(out_valid[0]), 128'd0);
      check("rst_data_out", data_out[0], 128'd0);
    end
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("nokey_in_ready", 128'(in_ready[0]), 128'd0);
      check("nokey_out_valid", 128'(out_valid[0]), 128'd0);
    end
    in_valid[0] = 1'b0;

    // UNROLL=1 encrypt and decrypt
    load_key(0, KEY_B);
    start_block(0, 1'b0, PT_B, CT_B, 10, -1);
    finish_block(0);
    start_block(0, 1'b1, CT_B, PT_B, 10, -1);
    finish_block(0);

    // UNROLL=2 and UNROLL=10 round trips
    for (int u = 1; u < 3; u++) begin
      load_key(u, KEY_C);
      start_block(u, 1'b0, PT_C, CT_C, (u == 1) ? 5 : 1, -1);
      finish_block(u);
      start_block(u, 1'b1, CT_C, PT_C, (u == 1) ? 5 : 1, -1);
      finish_block(u);
    end

    // Backpressure: result held for 20 cycles
    out_ready[0] = 1'b0;
    start_block(0, 1'b0, PT_B, CT_B, 10, -1);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("bp_out_valid", 128'(out_valid[0]), 128'd1);
      check("bp_data_out", data_out[0], CT_B);
      check("bp_in_ready", 128'(in_ready[0]), 128'd0);
    end
    out_ready[0] = 1'b1;
    finish_block(0);

    // Reset in RUN cycle 4 aborts the block and drops the key
    check("abort_in_ready", 128'(in_ready[0]), 128'd1);
    in_valid[0] = 1'b1;
    mode[0]     = 1'b0;
    data_in[0]  = PT_B;
    tick();
    in_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      check("abort_out_valid", 128'(out_valid[0]), 128'd0);
      check("abort_key_ok", 128'(in_ready[0]), 128'd0);
    end

    // KEY_LOAD during RUN is ignored; the old key stays cached
    load_key(0, KEY_B);
    start_block(0, 1'b0, PT_B, CT_B, 10, 3);
    finish_block(0);
    start_block(0, 1'b0, PT_B, CT_B, 10, -1);
    finish_block(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
